// File: rtl/scan_decoder.sv
// Registered one-hot line decoder with valid/ready handshake and an optional
// dwell-timed scan mode, compiled in by defining SCAN_DECODER_SCAN_EN.
module scan_decoder #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [2**SEL_W-1:0]   out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  wrap
);

  localparam int unsigned OUT_W = 2**SEL_W;
  localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

  typedef enum logic [1:0] {IDLE, EMPTY, FULL, SCAN} state_t;

  state_t             state, state_n;
  logic [OUT_W-1:0]   out_n;
  logic               out_valid_n;
  logic               wrap_n;
  logic               scan_req;
  logic [OUT_W-1:0]   sel_hot;

  assign sel_hot = ONE << in_sel;

`ifdef SCAN_DECODER_SCAN_EN
  logic [SEL_W-1:0]   idx, idx_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [DWELL_W-1:0] cnt_last;
  // Marks the first cycle idx sits at 0 after wrapping; wrap is its registered copy
  // so the pulse lines up with the cycle out first shows bit 0.
  logic               wrp, wrp_n;

  assign scan_req = mode;
  assign cnt_last = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
`else
  logic unused_cfg;

  assign scan_req   = 1'b0;
  assign unused_cfg = ^{mode, dwell};
`endif

  assign in_ready = en && !scan_req &&
                    ((state == EMPTY) || ((state == FULL) && out_ready));

  always_comb begin
    state_n     = state;
    out_n       = out;
    out_valid_n = out_valid;
    wrap_n      = 1'b0;
`ifdef SCAN_DECODER_SCAN_EN
    idx_n       = '0;
    cnt_n       = '0;
    wrp_n       = 1'b0;
`endif
    if (!en) begin
      state_n     = IDLE;
      out_n       = '0;
      out_valid_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_n     = scan_req ? SCAN : EMPTY;
          out_n       = '0;
          out_valid_n = 1'b0;
        end
        EMPTY, FULL: begin
          if (scan_req) begin
            state_n     = SCAN;
            out_n       = '0;
            out_valid_n = 1'b0;
          end else if ((state == EMPTY) || out_ready) begin
            if (in_valid) begin
              state_n     = FULL;
              out_n       = sel_hot;
              out_valid_n = 1'b1;
            end else begin
              state_n     = EMPTY;
              out_n       = '0;
              out_valid_n = 1'b0;
            end
          end
        end
`ifdef SCAN_DECODER_SCAN_EN
        SCAN: begin
          if (!scan_req) begin
            state_n     = EMPTY;
            out_n       = '0;
            out_valid_n = 1'b0;
          end else begin
            out_n       = ONE << idx;
            out_valid_n = 1'b1;
            wrap_n      = wrp;
            // >= so a shrinking dwell never strands the counter above the new limit.
            if (cnt >= cnt_last) begin
              cnt_n = '0;
              idx_n = idx + SEL_W'(1);
              wrp_n = (idx == '1);
            end else begin
              cnt_n = cnt + DWELL_W'(1);
              idx_n = idx;
            end
          end
        end
`endif
        default: begin
          state_n     = IDLE;
          out_n       = '0;
          out_valid_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out       <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_n;
      out       <= out_n;
      out_valid <= out_valid_n;
      wrap      <= wrap_n;
    end
  end

`ifdef SCAN_DECODER_SCAN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      cnt <= '0;
      wrp <= 1'b0;
    end else begin
      idx <= idx_n;
      cnt <= cnt_n;
      wrp <= wrp_n;
    end
  end
`endif

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder (SEL_W=3): stimulus queues expected {wrap,out}
// words, a negedge monitor pops them whenever the DUT presents an output.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_sel = '0;
  logic [7:0] dwell = '0;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       wrap;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic        scan_mon = 1'b0;
  logic [8:0]  q[$];

  scan_decoder #(.SEL_W(3), .DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .dwell(dwell),
    .out(out), .out_valid(out_valid), .out_ready(out_ready), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outputs are taken at negedge; a transfer happens when valid meets ready
  // (scan words are checked every valid cycle since scan ignores out_ready).
  always @(negedge clk) begin
    if (rst_n && out_valid && (out_ready || scan_mon)) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got out=%0h wrap=%0b expected none at %0t", out, wrap, $time);
      end else begin
        logic [8:0] e;
        e = q.pop_front();
        chk("out", 32'(out), 32'(e[7:0]));
        chk("wrap", 32'(wrap), 32'(e[8]));
      end
    end
  end

  initial begin
    logic [7:0] v;
    // Reset state
    #12;
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_out_valid", 32'(out_valid), 32'h0);

    // Direct decode with held output
    en = 1'b1; mode = 1'b0;
    step();
    chk("empty_in_ready", 32'(in_ready), 32'h1);
    chk("empty_out_valid", 32'(out_valid), 32'h0);
    in_valid = 1'b1; in_sel = 3'd5; out_ready = 1'b0;
    q.push_back({1'b0, 8'h20});
    step();
    in_valid = 1'b0;
    chk("full_out", 32'(out), 32'h20);
    chk("full_out_valid", 32'(out_valid), 32'h1);
    chk("full_in_ready_blocked", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_out", 32'(out), 32'h20);
      chk("hold_out_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    step();
    chk("drain_out", 32'(out), 32'h0);
    chk("drain_out_valid", 32'(out_valid), 32'h0);

    // Back-to-back full throughput
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_sel = 3'(i);
      chk("b2b_in_ready", 32'(in_ready), 32'h1);
      v = 8'h01 << i;
      q.push_back({1'b0, v});
      step();
      chk("b2b_out", 32'(out), 32'(v));
    end
    in_valid = 1'b0;
    step();
    chk("b2b_empty", 32'(out_valid), 32'h0);

    // Asynchronous reset while FULL
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd5;
    step();
    in_valid = 1'b0;
    chk("pre_rst_out", 32'(out), 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(out), 32'h0);
    chk("async_rst_out_valid", 32'(out_valid), 32'h0);
    en = 1'b0;
    step();
    rst_n = 1'b1;
    step();

`ifdef SCAN_DECODER_SCAN_EN
    // Mode change drops the held word
    en = 1'b1; mode = 1'b0;
    step();
    in_valid = 1'b1; in_sel = 3'd2;
    step();
    in_valid = 1'b0;
    chk("mc_full_out", 32'(out), 32'h04);
    mode = 1'b1; dwell = 8'd0;
    step();
    chk("mc_clear_out", 32'(out), 32'h0);
    chk("mc_clear_out_valid", 32'(out_valid), 32'h0);
    step();
    chk("mc_scan_out", 32'(out), 32'h01);
    chk("mc_scan_out_valid", 32'(out_valid), 32'h1);
    en = 1'b0;
    step();
    chk("en_low_out", 32'(out), 32'h0);

    // Scan, dwell=2, with in_valid/out_ready ignored
    dwell = 8'd2; mode = 1'b1; in_valid = 1'b1; in_sel = 3'd6; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = 8'h01 << i;
      q.push_back({1'b0, v});
      q.push_back({1'b0, v});
    end
    q.push_back({1'b1, 8'h01});
    q.push_back({1'b0, 8'h01});
    q.push_back({1'b0, 8'h02});
    scan_mon = 1'b1;
    en = 1'b1;
    step();
    chk("scan_in_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 19; i++) step();
    en = 1'b0;
    step();
    scan_mon = 1'b0;
    in_valid = 1'b0;

    // Scan, dwell=0 advances every cycle
    dwell = 8'd0;
    for (int i = 0; i < 8; i++) q.push_back({1'b0, 8'h01 << i});
    q.push_back({1'b1, 8'h01});
    for (int i = 1; i < 8; i++) q.push_back({1'b0, 8'h01 << i});
    scan_mon = 1'b1;
    en = 1'b1;
    step();
    for (int i = 0; i < 16; i++) step();
    en = 1'b0;
    step();
    scan_mon = 1'b0;
`else
    // Without scan support mode is ignored and wrap stays low
    en = 1'b1; mode = 1'b1; dwell = 8'd3; out_ready = 1'b1;
    step();
    chk("noscan_in_ready", 32'(in_ready), 32'h1);
    in_valid = 1'b1; in_sel = 3'd3;
    q.push_back({1'b0, 8'h08});
    step();
    in_valid = 1'b0;
    step();
    chk("noscan_out", 32'(out), 32'h0);
    chk("noscan_wrap", 32'(wrap), 32'h0);
    en = 1'b0;
    step();
`endif

    for (int i = 0; i < 50 && q.size() != 0; i++) step();
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 SHALL have parameter SEL_W, default 3: select width; output width is 2**SEL_W.
REQ-002 SHALL have parameter DWELL_W, default 8: width of scan dwell count.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1: block enable.
REQ-006 SHALL have port mode, input, 1: 0 = direct decode, 1 = scan.
REQ-007 SHALL have port in_valid, input, 1: in_sel valid (direct mode).
REQ-008 SHALL have port in_ready, output, 1: block accepts in_sel this cycle.
REQ-009 SHALL have port in_sel, input, SEL_W: line index to decode.
REQ-010 SHALL have port dwell, input, DWELL_W: cycles per line in scan mode.
REQ-011 SHALL have port out, output, 2**SEL_W: registered one-hot or all-zero output.
REQ-012 SHALL have port out_valid, output, 1: out holds a valid decoded word.
REQ-013 SHALL have port out_ready, input, 1: downstream consumes out when out_valid.
REQ-014 SHALL have port wrap, output, 1: one-cycle pulse on scan wrap-around.

Function
REQ-015 SHALL implement states IDLE, EMPTY, FULL, SCAN; state is IDLE whenever en=0.
REQ-016 IDLE: out=0, out_valid=0, in_ready=0, wrap=0; en=1 with mode=0 -> EMPTY, en=1 with mode=1 -> SCAN.
REQ-017 EMPTY: in_ready=1, out_valid=0; in_valid=1 -> out <= 1<<in_sel, out_valid <= 1, state FULL (latency 1 cycle).
REQ-018 FULL: out_valid=1, in_ready=out_ready; out and out_valid SHALL be held stable until out_ready=1.
REQ-019 FULL with out_ready=1 and in_valid=1: new word loaded the same edge, state stays FULL (full throughput, no bubble).
REQ-020 FULL with out_ready=1 and in_valid=0: out <= 0, out_valid <= 0, state EMPTY.
REQ-021 SCAN: in_ready=0, out_valid=1, out = 1<<idx; idx and dwell counter both start at 0 on entry.
REQ-022 SCAN: dwell counter increments each cycle; when it reaches max(dwell,1)-1 it SHALL clear and idx SHALL advance by 1.
REQ-023 idx SHALL wrap from 2**SEL_W-1 to 0; wrap SHALL be 1 in exactly the cycle out first shows bit 0 after the wrap.
REQ-024 dwell=0 SHALL behave as dwell=1 (advance every cycle); dwell changes take effect at the next comparison.
REQ-025 SCAN ignores out_ready and in_valid.
REQ-026 mode change while en=1: next edge clears out, out_valid and wrap and enters EMPTY (mode=0) or SCAN (mode=1); a FULL word not yet consumed is discarded.
REQ-027 en falling: next edge enters IDLE with all outputs cleared; pending words discarded.
REQ-028 out SHALL never have more than one bit set.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, out=0, out_valid=0, in_ready=0, wrap=0, idx=0, dwell counter=0.
REQ-030 After rst_n rises, first state change SHALL occur at the first rising clk edge that samples en=1.

Configuration
REQ-031 Macro SCAN_DECODER_SCAN_EN SHALL compile in SCAN state, idx/dwell counters and wrap logic.
REQ-032 Without SCAN_DECODER_SCAN_EN: mode and dwell SHALL be ignored, block operates as direct decode only, wrap SHALL be tied 0.

Verification (SEL_W=3)
REQ-033 Reset mid-FULL (out=8'h20) -> out=0, out_valid=0 asynchronously, before next clk edge.
REQ-034 Direct: en=1, mode=0, in_sel=3'd5 valid one cycle, out_ready=0 -> out=8'h20, out_valid=1 held until out_ready=1, then out=0.
REQ-035 Back-to-back: in_sel 0,1,...,7 on consecutive cycles, out_ready=1 -> out 8'h01..8'h80 on consecutive cycles, in_ready constantly 1.
REQ-036 Scan: mode=1, dwell=2 -> out 01,01,02,02,...,80,80,01; wrap=1 only in first 01 cycle after 80.
REQ-037 Scan dwell=0 -> out advances every cycle, wrap every 8 cycles.
REQ-038 Mode 0->1 while FULL with out=8'h04 -> next cycle out=0, then out=8'h01 in SCAN; held word lost.
